ahbmtx_in_hold: RTL and testbench
=================================

# ahbmtx_in_hold

Input stage of the AHB bus matrix, one instance per master port. It sits between an AHB-Lite master and the per-slave output-stage arbiters. It raises a request toward the arbiters and presents the address-phase signals to them. If no arbiter accepts the transfer in the cycle it is issued, the block registers and holds the address phase. While a transfer is held or waiting in its data phase, it drives the master's HREADYOUT from the slave selected by the owning output stage.

## Interface
- ADDR_W, 32, address width
- Reset is synchronous and active-low. The block runs on one clock, HCLK, and one reset, HRESETn; both are sampled on the rising edge of HCLK.
- HCLK  in  1  AHB system clock
- HRESETn  in  1  synchronous active-low reset
- HSELS  in  1  master-side select
- HADDRS  in  ADDR_W  master address
- HTRANSS  in  2  master transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  locked
- HREADYS  in  1  bus HREADY seen by master
- HREADYOUTS  out  1  ready back to master
- HRESPS  out  1  response back to master (1 = ERROR)
- req_o  out  1  address-phase request to output stages
- addr_o, trans_o, write_o, size_o, burst_o, prot_o, lock_o  out  ADDR_W/2/1/3/3/4/1  address phase presented to output stages
- held_o  out  1  addr_o etc. come from the hold register
- addr_accept_i  in  1  an output stage selected this port while its HREADYM=1 (address accepted this cycle)
- dp_ready_i  in  1  HREADYOUT of slave owning this port's data phase
- dp_resp_i  in  1  HRESP of that slave

## Operation
- A transfer is live (live_tr) when HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ). IDLE and BUSY are never requests.
- Presented phase: if pend=1, outputs come from the hold register and held_o=1. Otherwise the live HADDRS.. signals pass straight through and held_o=0.
- Request: req_o = pend | live_tr.
- Hold capture: on live_tr & ~addr_accept_i, load all address-phase signals into the hold register and set pend=1.
- Hold release: when pend & addr_accept_i, pend clears at the next edge.
- pend=1 implies HREADYOUTS=0, so the master cannot issue a new transfer. Consequently live_tr and pend are never both 1.
- Data-phase tracker dp_active:
  - next = 1 if req_o & addr_accept_i
  - else 0 if dp_ready_i
  - else it holds its value.
- HREADYOUTS:
  - 0 if pend
  - else dp_ready_i if dp_active
  - else 1.
- HRESPS = dp_active & dp_resp_i; otherwise 0. ERROR uses the two-cycle sequence (resp=1 with ready=0, then resp=1 with ready=1) and is passed through unmodified.
- A held transfer is never dropped, including when the preceding data phase ends in ERROR. The lock value is held together with the address phase.
- addr_accept_i while req_o=0 is ignored: no state change.

## Timing
- Reset (HRESETn=0 at an edge):
  - pend=0, dp_active=0, hold register all zeros
  - HREADYOUTS=1, HRESPS=0, req_o=0 (with no live transfer), held_o=0.
  - Reset mid-hold discards the held transfer.
- Pass-through, accepted in the same cycle: zero added latency. The data phase starts at the next edge.
- Not accepted: the held transfer is presented from the next cycle and re-requested every cycle until accepted. HREADYOUTS stays 0 from the cycle after issue until the held transfer's data phase completes.
- A held transfer accepted in cycle N: pend=0 and dp_active=1 in N+1, and HREADYOUTS follows dp_ready_i from N+1.
- Back-to-back pipelined transfers are supported: a new accept in the same cycle as dp_ready_i=1 keeps dp_active=1.

## Test plan
- Reset → HREADYOUTS=1, HRESPS=0, req_o=0, held_o=0. A live NONSEQ at 0x2000_0000 with addr_accept_i=1 → addr_o=0x2000_0000 in the same cycle, held_o=0, dp_active=1 at the next edge.
- NONSEQ write to 0x4000_0010 with addr_accept_i=0 for 3 cycles, then 1 → held_o=1 and addr_o=0x4000_0010 for cycles 2–4. HREADYOUTS=0 until the data-phase dp_ready_i=1. The master's HADDRS changing during the hold is ignored.
- 4-beat INCR4 burst, all accepted, dp_ready_i=1 → req_o high 4 cycles, HREADYOUTS=1 throughout, dp_active drops one cycle after the last beat.
- Data phase with dp_ready_i=0 for 2 cycles then ERROR sequence (resp=1/ready=0, resp=1/ready=1) → HRESPS/HREADYOUTS mirror it exactly. A transfer held during the error is still issued afterwards.
- HRESETn=0 while pend=1 → at the next edge pend=0, req_o=0, HREADYOUTS=1, and no request after reset release.
- IDLE and BUSY with HSELS=1 and addr_accept_i=0 → req_o=0, no capture, HREADYOUTS=1.

Source files
------------

// File: rtl/ahbmtx_in_hold.sv
// ahbmtx_in_hold: AHB matrix input stage; holds an unaccepted address phase and
// tracks the data phase to drive the master's HREADYOUT/HRESP.  Rev 1.0
`default_nettype none

module ahbmtx_in_hold #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        trans_o,
  output logic              write_o,
  output logic [2:0]        size_o,
  output logic [2:0]        burst_o,
  output logic [3:0]        prot_o,
  output logic              lock_o,
  output logic              held_o,
  input  logic              addr_accept_i,
  input  logic              dp_ready_i,
  input  logic              dp_resp_i
);

  logic              r_pend;
  logic              r_dp_active;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [3:0]        r_prot;
  logic              r_lock;

  logic w_live;
  logic w_req;

  assign w_live = HSELS & HREADYS & HTRANSS[1];
  assign w_req  = r_pend | w_live;

  // The master is stalled while pend is set, so live and held never coexist.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_trans <= 2'b00;
      r_write <= 1'b0;
      r_size  <= 3'b000;
      r_burst <= 3'b000;
      r_prot  <= 4'b0000;
      r_lock  <= 1'b0;
    end else if (r_pend) begin
      if (addr_accept_i) r_pend <= 1'b0;
    end else if (w_live && !addr_accept_i) begin
      r_pend  <= 1'b1;
      r_addr  <= HADDRS;
      r_trans <= HTRANSS;
      r_write <= HWRITES;
      r_size  <= HSIZES;
      r_burst <= HBURSTS;
      r_prot  <= HPROTS;
      r_lock  <= HMASTLOCKS;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dp_active <= 1'b0;
    end else if (w_req && addr_accept_i) begin
      r_dp_active <= 1'b1;
    end else if (dp_ready_i) begin
      r_dp_active <= 1'b0;
    end
  end

  always_comb begin
    req_o   = w_req;
    held_o  = r_pend;
    addr_o  = HADDRS;
    trans_o = HTRANSS;
    write_o = HWRITES;
    size_o  = HSIZES;
    burst_o = HBURSTS;
    prot_o  = HPROTS;
    lock_o  = HMASTLOCKS;
    if (r_pend) begin
      addr_o  = r_addr;
      trans_o = r_trans;
      write_o = r_write;
      size_o  = r_size;
      burst_o = r_burst;
      prot_o  = r_prot;
      lock_o  = r_lock;
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    if (r_pend)           HREADYOUTS = 1'b0;
    else if (r_dp_active) HREADYOUTS = dp_ready_i;
    HRESPS = r_dp_active & dp_resp_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_ahbmtx_in_hold.sv
// tb_ahbmtx_in_hold: directed self-checking bench for ahbmtx_in_hold.
`default_nettype none

module tb_ahbmtx_in_hold;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        req_o;
  logic [31:0] addr_o;
  logic [1:0]  trans_o;
  logic        write_o;
  logic [2:0]  size_o;
  logic [2:0]  burst_o;
  logic [3:0]  prot_o;
  logic        lock_o;
  logic        held_o;
  logic        addr_accept_i;
  logic        dp_ready_i;
  logic        dp_resp_i;

  int checks = 0;
  int errors = 0;

  ahbmtx_in_hold #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .req_o(req_o), .addr_o(addr_o),
    .trans_o(trans_o), .write_o(write_o), .size_o(size_o), .burst_o(burst_o),
    .prot_o(prot_o), .lock_o(lock_o), .held_o(held_o),
    .addr_accept_i(addr_accept_i), .dp_ready_i(dp_ready_i), .dp_resp_i(dp_resp_i)
  );

  always #5 HCLK = ~HCLK;

  // Advance to just after the next rising edge; inputs change there and
  // outputs are sampled 1 time unit later, well clear of either edge.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    HSELS = 1'b0; HADDRS = 32'h0; HTRANSS = 2'b00; HWRITES = 1'b0;
    HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
    HREADYS = 1'b1; addr_accept_i = 1'b0; dp_ready_i = 1'b1; dp_resp_i = 1'b0;
  endtask

  task automatic issue(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic acc);
    HSELS = 1'b1; HTRANSS = tr; HADDRS = a; HWRITES = wr; HREADYS = 1'b1; addr_accept_i = acc;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; idle();
    cyc(); cyc(); #1;
    checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b exp 1", HREADYOUTS); end
    checks++; if (HRESPS !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b exp 0", HRESPS); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req_o); end
    checks++; if (held_o !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", held_o); end
    HRESETn = 1'b1;
    cyc();
  endtask

  task automatic test_passthrough();
    issue(2'b10, 32'h2000_0000, 1'b0, 1'b1); dp_ready_i = 1'b1; #1;
    checks++; if (addr_o !== 32'h2000_0000) begin errors++; $display("FAIL pt_addr got %h exp 20000000", addr_o); end
    checks++; if (held_o !== 1'b0) begin errors++; $display("FAIL pt_held got %b exp 0", held_o); end
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL pt_req got %b exp 1", req_o); end
    checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL pt_ready_addr got %b exp 1", HREADYOUTS); end
    cyc(); idle(); dp_ready_i = 1'b0; #1;
    checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL pt_dp_active got %b exp 0", HREADYOUTS); end
    dp_ready_i = 1'b1; #1;
    checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL pt_dp_follow got %b exp 1", HREADYOUTS); end
    cyc(); dp_ready_i = 1'b0; #1;
    checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL pt_dp_done got %b exp 1", HREADYOUTS); end
    cyc(); idle();
  endtask

  task automatic test_hold();
    issue(2'b10, 32'h4000_0010, 1'b1, 1'b0); HMASTLOCKS = 1'b1; HPROTS = 4'b1010; #1;
    checks++; if (req_o !== 1'b1 || held_o !== 1'b0) begin errors++; $display("FAIL hold_c1 got req=%b held=%b exp req=1 held=0", req_o, held_o); end
    cyc();
    for (int c = 2; c <= 4; c++) begin
      HADDRS = 32'hDEAD_BEEF; HWRITES = 1'b0; HMASTLOCKS = 1'b0; HPROTS = 4'b0000;
      HREADYS = 1'b0; addr_accept_i = (c == 4); #1;
      checks++; if (held_o !== 1'b1 || addr_o !== 32'h4000_0010) begin errors++; $display("FAIL hold_c%0d got held=%b addr=%h exp held=1 addr=40000010", c, held_o, addr_o); end
      checks++; if (write_o !== 1'b1 || lock_o !== 1'b1 || prot_o !== 4'b1010 || trans_o !== 2'b10) begin errors++; $display("FAIL hold_attr_c%0d got w=%b l=%b p=%h t=%b exp 1 1 a 10", c, write_o, lock_o, prot_o, trans_o); end
      checks++; if (req_o !== 1'b1 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL hold_req_c%0d got req=%b rdy=%b exp 1 0", c, req_o, HREADYOUTS); end
      cyc();
    end
    idle(); HREADYS = 1'b0; dp_ready_i = 1'b0; #1;
    checks++; if (held_o !== 1'b0 || req_o !== 1'b0 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL hold_dp_wait got held=%b req=%b rdy=%b exp 0 0 0", held_o, req_o, HREADYOUTS); end
    cyc(); dp_ready_i = 1'b1; #1;
    checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL hold_dp_done got %b exp 1", HREADYOUTS); end
    cyc(); idle();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      issue((b == 0) ? 2'b10 : 2'b11, 32'h0000_0100 + 32'(4 * b), 1'b0, 1'b1);
      HBURSTS = 3'b011; dp_ready_i = 1'b1; #1;
      checks++; if (req_o !== 1'b1 || HREADYOUTS !== 1'b1) begin errors++; $display("FAIL burst_b%0d got req=%b rdy=%b exp 1 1", b, req_o, HREADYOUTS); end
      checks++; if (addr_o !== 32'h0000_0100 + 32'(4 * b) || burst_o !== 3'b011) begin errors++; $display("FAIL burst_addr_b%0d got %h/%b exp %h/011", b, addr_o, burst_o, 32'h100 + 32'(4 * b)); end
      cyc();
    end
    idle(); dp_ready_i = 1'b0; #1;
    checks++; if (req_o !== 1'b0 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL burst_last_dp got req=%b rdy=%b exp 0 0", req_o, HREADYOUTS); end
    dp_ready_i = 1'b1;
    cyc(); dp_ready_i = 1'b0; #1;
    checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL burst_dp_drop got %b exp 1", HREADYOUTS); end
    cyc(); idle();
  endtask

  task automatic test_error();
    issue(2'b10, 32'h3000_0000, 1'b0, 1'b1); #1;
    cyc(); idle();
    for (int c = 0; c < 2; c++) begin
      dp_ready_i = 1'b0; dp_resp_i = 1'b0; #1;
      checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 1'b0) begin errors++; $display("FAIL err_wait%0d got rdy=%b resp=%b exp 0 0", c, HREADYOUTS, HRESPS); end
      cyc();
    end
    dp_ready_i = 1'b0; dp_resp_i = 1'b1; #1;
    checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 1'b1) begin errors++; $display("FAIL err_first got rdy=%b resp=%b exp 0 1", HREADYOUTS, HRESPS); end
    cyc();
    dp_ready_i = 1'b1; dp_resp_i = 1'b1;
    issue(2'b10, 32'h5000_0020, 1'b1, 1'b0); #1;
    checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL err_second got rdy=%b resp=%b req=%b exp 1 1 1", HREADYOUTS, HRESPS, req_o); end
    cyc(); idle(); HREADYS = 1'b0; #1;
    checks++; if (held_o !== 1'b1 || addr_o !== 32'h5000_0020 || req_o !== 1'b1) begin errors++; $display("FAIL err_held got held=%b addr=%h req=%b exp 1 50000020 1", held_o, addr_o, req_o); end
    checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 1'b0) begin errors++; $display("FAIL err_held_rdy got rdy=%b resp=%b exp 0 0", HREADYOUTS, HRESPS); end
    addr_accept_i = 1'b1;
    cyc(); idle(); dp_ready_i = 1'b0; #1;
    checks++; if (held_o !== 1'b0 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL err_issued got held=%b rdy=%b exp 0 0", held_o, HREADYOUTS); end
    dp_ready_i = 1'b1;
    cyc(); idle();
  endtask

  task automatic test_reset_mid_hold();
    issue(2'b10, 32'h6000_0000, 1'b0, 1'b0); #1;
    cyc(); idle(); HREADYS = 1'b0; #1;
    checks++; if (held_o !== 1'b1) begin errors++; $display("FAIL rst_hold_pre got %b exp 1", held_o); end
    HRESETn = 1'b0;
    cyc(); #1;
    checks++; if (req_o !== 1'b0 || held_o !== 1'b0 || HREADYOUTS !== 1'b1) begin errors++; $display("FAIL rst_hold got req=%b held=%b rdy=%b exp 0 0 1", req_o, held_o, HREADYOUTS); end
    HRESETn = 1'b1; HREADYS = 1'b1; addr_accept_i = 1'b1;
    cyc(); cyc(); #1;
    checks++; if (req_o !== 1'b0 || held_o !== 1'b0 || HREADYOUTS !== 1'b1) begin errors++; $display("FAIL rst_hold_after got req=%b held=%b rdy=%b exp 0 0 1", req_o, held_o, HREADYOUTS); end
    idle();
  endtask

  task automatic test_idle_busy();
    for (int t = 0; t < 2; t++) begin
      issue(t[1:0], 32'h7000_0000, 1'b0, 1'b0); #1;
      checks++; if (req_o !== 1'b0 || HREADYOUTS !== 1'b1) begin errors++; $display("FAIL idlebusy_t%0d got req=%b rdy=%b exp 0 1", t, req_o, HREADYOUTS); end
      cyc(); #1;
      checks++; if (held_o !== 1'b0 || req_o !== 1'b0) begin errors++; $display("FAIL idlebusy_cap%0d got held=%b req=%b exp 0 0", t, held_o, req_o); end
    end
    idle(); addr_accept_i = 1'b1;
    cyc(); dp_ready_i = 1'b0; addr_accept_i = 1'b0; #1;
    checks++; if (HREADYOUTS !== 1'b1 || held_o !== 1'b0) begin errors++; $display("FAIL stray_accept got rdy=%b held=%b exp 1 0", HREADYOUTS, held_o); end
    cyc(); idle();
  endtask

  initial begin
    HRESETn = 1'b0; idle();
    test_reset();
    test_passthrough();
    test_hold();
    test_back_to_back();
    test_error();
    test_reset_mid_hold();
    test_idle_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
